clock_period_tracker: RTL and testbench
=======================================

CLOCK_PERIOD_TRACKER -- requirements
Module: clock_period_tracker

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, giving the width of the period counter and of all period values.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, giving the number of consecutive matching periods required for lock (legal range 2..15).
REQ-003 SHALL have parameter TOLERANCE, default 2, giving the maximum absolute difference in cycles for two periods to match.
REQ-004 SHALL have port sys_dom_i, input, common_p::clk_dom, carrying the single clock and the reset; reset is synchronous and active-low.
REQ-005 SHALL have port tracker_en_i, input, 1 bit; block enable.
REQ-006 SHALL have port edge_event_i, input, 1 bit; single-cycle primary-edge pulse from event_recovery's recovered_events_o.
REQ-007 SHALL have port timeout_cycles_i, input, PERIOD_W bits; loss-of-clock threshold in cycles, where 0 disables timeout.
REQ-008 SHALL have port lost_clear_i, input, 1 bit; clears sticky lost_o.
REQ-009 SHALL have port period_o, output, PERIOD_W bits; last accepted period in sys cycles.
REQ-010 SHALL have port period_valid_o, output, 1 bit; one-cycle pulse when period_o updates.
REQ-011 SHALL have port locked_o, output, 1 bit; high while in LOCKED.
REQ-012 SHALL have port lost_o, output, 1 bit; sticky loss-of-clock flag.

Function
REQ-013 SHALL implement states IDLE, ARM, ACQUIRE, LOCKED and LOST.
REQ-014 SHALL go to IDLE from any state when tracker_en_i=0, clearing the counter, the match count, period_o, period_valid_o and locked_o; lost_o is held.
REQ-015 SHALL move IDLE->ARM when tracker_en_i=1; in ARM, the first edge_event_i zeroes the counter, produces no measurement, and moves to ACQUIRE.
REQ-016 SHALL increment the cycle counter every cycle outside IDLE, saturating at all-ones.
REQ-017 SHALL, on edge_event_i, take measurement = counter+1 (saturated), then zero the counter.
REQ-018 SHALL treat a measurement matching the reference when |meas-ref| <= TOLERANCE; a saturated measurement never matches.
REQ-019 SHALL, in ACQUIRE, increment the match count on a match, and on a mismatch zero the match count and load ref=meas; the first measurement after ARM or LOST loads ref only.
REQ-020 SHALL enter LOCKED when the match count reaches LOCK_COUNT-1, i.e. LOCK_COUNT consecutive equal-within-tolerance periods.
REQ-021 SHALL, in LOCKED, update ref on every match; a mismatch returns the block to ACQUIRE with match count 0, ref=meas and locked_o=0 on the next cycle.
REQ-022 SHALL update period_o and pulse period_valid_o on the cycle after the edge, for every matching measurement in ACQUIRE or LOCKED.
REQ-023 SHALL, in ACQUIRE or LOCKED with timeout_cycles_i!=0, move to LOST and set lost_o when counter==timeout_cycles_i with no edge; locked_o is 0 in LOST.
REQ-024 SHALL, in LOST, treat the next edge like ARM (counter zeroed, then ACQUIRE); lost_o remains set.
REQ-025 SHALL give edge_event_i priority when an edge and a timeout occur in the same cycle (no loss).
REQ-026 SHALL clear lost_o on lost_clear_i, except that a simultaneous new loss keeps lost_o set.

Reset
REQ-027 SHALL, on sys_dom_i reset low at a clock edge, enter IDLE with counter=0, match=0, ref=0, period_o=0, period_valid_o=0, locked_o=0 and lost_o=0.
REQ-028 SHALL let reset mid-measurement discard the partial count; no period_valid_o pulse occurs for it.

Configuration
REQ-029 SHALL, with macro SIR_CLKS_ALOT_PERIOD_AVG_EN defined, output period_o=(prev_period_o+meas)>>1 (rounded down, computed PERIOD_W+1 wide) in LOCKED; on entering LOCKED, period_o=meas.
REQ-030 SHALL, without SIR_CLKS_ALOT_PERIOD_AVG_EN, output period_o=meas directly and include no averaging logic.

Verification
REQ-031 SHALL cover: edges every 10 cycles, defaults -> first period_valid_o on the 3rd edge with period_o=10, locked_o=1 after the 5th edge.
REQ-032 SHALL cover: locked at 10, then one period of 13 -> locked_o=0 the cycle after that edge, state ACQUIRE, no period_valid_o pulse.
REQ-033 SHALL cover: locked at 10, periods 9/11/10 -> lock held, period_o follows (AVG_EN: 9, 10, 10).
REQ-034 SHALL cover: timeout_cycles_i=50, edges stop -> lost_o=1 and locked_o=0 when the counter hits 50; lost_clear_i then clears lost_o.
REQ-035 SHALL cover: edge coincident with counter==timeout -> no loss; lost_clear_i coincident with a new loss -> lost_o stays 1.
REQ-036 SHALL cover: reset low mid-ACQUIRE -> all outputs 0 next cycle, ARM re-entered after reset release with tracker_en_i=1.

Source files
------------

// File: rtl/clock_period_tracker.sv
// Measures the period of a recovered edge stream in sys cycles, locks after LOCK_COUNT consistent periods.
// Optional period averaging while locked: define SIR_CLKS_ALOT_PERIOD_AVG_EN.
package common_p;
   typedef struct packed {
      logic clk;
      logic rst_n;
   } clk_dom;
endpackage

module clock_period_tracker #(
   parameter int PERIOD_W   = 16,
   parameter int LOCK_COUNT = 4,
   parameter int TOLERANCE  = 2
) (
   input  common_p::clk_dom    sys_dom_i,
   input  logic                tracker_en_i,
   input  logic                edge_event_i,
   input  logic [PERIOD_W-1:0] timeout_cycles_i,
   input  logic                lost_clear_i,
   output logic [PERIOD_W-1:0] period_o,
   output logic                period_valid_o,
   output logic                locked_o,
   output logic                lost_o
);

   localparam logic [3:0]              LOCK_LAST = 4'(LOCK_COUNT - 1);
   localparam logic signed [PERIOD_W:0] TOL_S    = (PERIOD_W + 1)'(TOLERANCE);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACQUIRE, S_LOCKED, S_LOST} state_t;

   logic                clk;
   logic                rst_n;
   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [3:0]          match_q, match_d;
   logic [PERIOD_W-1:0] period_ref_q, period_ref_d;
   logic                first_q, first_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                valid_q, valid_d;
   logic                lost_q, lost_d;
   logic [PERIOD_W-1:0] meas;
   logic [PERIOD_W-1:0] locked_period;
   logic                hit;
   logic                timeout_hit;

   assign clk   = sys_dom_i.clk;
   assign rst_n = sys_dom_i.rst_n;

   function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // An all-ones measurement means the counter overflowed, so it can never be trusted as a match.
   function automatic logic within_tol(input logic [PERIOD_W-1:0] m, input logic [PERIOD_W-1:0] r);
      logic signed [PERIOD_W:0] diff;
      diff = signed'({1'b0, m}) - signed'({1'b0, r});
      if (diff[PERIOD_W]) diff = -diff;
      return !(&m) && (diff <= TOL_S);
   endfunction

   assign meas        = sat_inc(cnt_q);
   assign hit         = within_tol(meas, period_ref_q);
   assign timeout_hit = (timeout_cycles_i != '0) && (cnt_q == timeout_cycles_i);

`ifdef SIR_CLKS_ALOT_PERIOD_AVG_EN
   assign locked_period = PERIOD_W'(({1'b0, period_q} + {1'b0, meas}) >> 1);
`else
   assign locked_period = meas;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         match_q      <= '0;
         period_ref_q <= '0;
         first_q      <= 1'b0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         lost_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         match_q      <= match_d;
         period_ref_q <= period_ref_d;
         first_q      <= first_d;
         period_q     <= period_d;
         valid_q      <= valid_d;
         lost_q       <= lost_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      match_d      = match_q;
      period_ref_d = period_ref_q;
      first_d      = first_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      lost_d       = lost_q;
      // Clear first so a loss detected in the same cycle wins.
      if (lost_clear_i) lost_d = 1'b0;
      if (!tracker_en_i) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         match_d  = '0;
         period_d = '0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_ARM;
            S_ARM, S_LOST: begin
               if (edge_event_i) begin
                  cnt_d   = '0;
                  match_d = '0;
                  first_d = 1'b1;
                  state_d = S_ACQUIRE;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            S_ACQUIRE, S_LOCKED: begin
               if (edge_event_i) begin
                  cnt_d = '0;
                  if (first_q) begin
                     period_ref_d = meas;
                     first_d      = 1'b0;
                  end else if (!hit) begin
                     state_d      = S_ACQUIRE;
                     match_d      = '0;
                     period_ref_d = meas;
                  end else if (state_q == S_LOCKED) begin
                     period_ref_d = meas;
                     period_d     = locked_period;
                     valid_d      = 1'b1;
                  end else begin
                     match_d  = match_q + 4'd1;
                     period_d = meas;
                     valid_d  = 1'b1;
                     if (match_d == LOCK_LAST) state_d = S_LOCKED;
                  end
               end else begin
                  cnt_d = sat_inc(cnt_q);
                  if (timeout_hit) begin
                     state_d = S_LOST;
                     lost_d  = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      period_o       = period_q;
      period_valid_o = valid_q;
      locked_o       = (state_q == S_LOCKED);
      lost_o         = lost_q;
   end

endmodule

// File: tb/tb_clock_period_tracker.sv
// Directed bench for clock_period_tracker with a timestamp-based reference model checked every cycle.
module tb_clock_period_tracker;

   localparam int PW   = 16;
   localparam int LC   = 4;
   localparam int TOL  = 2;
   localparam int MAXP = (1 << PW) - 1;
   localparam int M_IDLE = 0, M_ARM = 1, M_ACQ = 2, M_LOCK = 3, M_LOST = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            tracker_en = 1'b0;
   logic            edge_event = 1'b0;
   logic [PW-1:0]   timeout_cycles = '0;
   logic            lost_clear = 1'b0;
   logic [PW-1:0]   period_o;
   logic            period_valid_o;
   logic            locked_o;
   logic            lost_o;
   common_p::clk_dom sys_dom;

   assign sys_dom = {clk, rst_n};

   always #5 clk = ~clk;

   clock_period_tracker #(.PERIOD_W(PW), .LOCK_COUNT(LC), .TOLERANCE(TOL)) dut (
      .sys_dom_i       (sys_dom),
      .tracker_en_i    (tracker_en),
      .edge_event_i    (edge_event),
      .timeout_cycles_i(timeout_cycles),
      .lost_clear_i    (lost_clear),
      .period_o        (period_o),
      .period_valid_o  (period_valid_o),
      .locked_o        (locked_o),
      .lost_o          (lost_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the counter is the distance from an anchor timestamp; a run queue holds the
   // periods accepted since acquisition restarted (run[0] is the acquisition reference).
   int  cyc = 0;
   int  anchor = 0;
   int  m_mode = M_IDLE;
   int  m_per = 0;
   bit  m_vld = 1'b0;
   bit  m_lost = 1'b0;
   bit  ready = 1'b0;
   int  run[$];

   always @(posedge clk) begin : model
      int el, cnt_v, meas_v, base, d;
      bit good, loss;
      cyc = cyc + 1;
      if (!rst_n) begin
         m_mode = M_IDLE; anchor = cyc + 1; run.delete();
         m_per = 0; m_vld = 1'b0; m_lost = 1'b0; ready = 1'b1;
      end else begin
         el     = cyc - anchor;
         cnt_v  = (el > MAXP) ? MAXP : el;
         meas_v = (el + 1 > MAXP) ? MAXP : el + 1;
         m_vld  = 1'b0;
         loss   = 1'b0;
         if (!tracker_en) begin
            m_mode = M_IDLE; anchor = cyc + 1; run.delete(); m_per = 0;
         end else if (m_mode == M_IDLE) begin
            m_mode = M_ARM; anchor = cyc + 1;
         end else if (m_mode == M_ARM || m_mode == M_LOST) begin
            if (edge_event) begin
               anchor = cyc + 1; run.delete(); m_mode = M_ACQ;
            end
         end else if (edge_event) begin
            anchor = cyc + 1;
            if (run.size() == 0) begin
               run.push_back(meas_v);
            end else begin
               base = (m_mode == M_LOCK) ? run[$] : run[0];
               d = meas_v - base;
               if (d < 0) d = -d;
               good = (meas_v != MAXP) && (d <= TOL);
               if (good) begin
                  m_vld = 1'b1;
`ifdef SIR_CLKS_ALOT_PERIOD_AVG_EN
                  m_per = (m_mode == M_LOCK) ? (m_per + meas_v) / 2 : meas_v;
`else
                  m_per = meas_v;
`endif
                  run.push_back(meas_v);
                  if (m_mode == M_ACQ && run.size() == LC) m_mode = M_LOCK;
               end else begin
                  m_mode = M_ACQ; run.delete(); run.push_back(meas_v);
               end
            end
         end else if (timeout_cycles != 0 && cnt_v == int'(timeout_cycles)) begin
            loss = 1'b1; m_mode = M_LOST;
         end
         if (lost_clear) m_lost = 1'b0;
         if (loss) m_lost = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (ready) begin
         check("period_o", int'(period_o), m_per);
         check("period_valid_o", int'(period_valid_o), int'(m_vld));
         check("locked_o", int'(locked_o), (m_mode == M_LOCK) ? 1 : 0);
         check("lost_o", int'(lost_o), int'(m_lost));
      end
   end

   task automatic step(input logic e);
      edge_event = e;
      @(negedge clk);
      edge_event = 1'b0;
   endtask

   task automatic gap_edge(input int p);
      repeat (p - 1) step(1'b0);
      step(1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(1'b0);
      step(1'b0);
      check("rst_period", int'(period_o), 0);
      check("rst_valid", int'(period_valid_o), 0);
      check("rst_locked", int'(locked_o), 0);
      check("rst_lost", int'(lost_o), 0);

      // Acquire and lock on a period of 10
      rst_n = 1'b1; tracker_en = 1'b1;
      repeat (4) step(1'b0);
      step(1'b1);
      gap_edge(10);
      check("acq_edge2_valid", int'(period_valid_o), 0);
      gap_edge(10);
      check("acq_edge3_valid", int'(period_valid_o), 1);
      check("acq_edge3_period", int'(period_o), 10);
      check("acq_edge3_locked", int'(locked_o), 0);
      gap_edge(10);
      check("acq_edge4_locked", int'(locked_o), 0);
      gap_edge(10);
      check("acq_edge5_locked", int'(locked_o), 1);

      // Jitter within tolerance keeps lock
      gap_edge(9);
      check("jit9_locked", int'(locked_o), 1);
      check("jit9_period", int'(period_o), 9);
      gap_edge(11);
`ifdef SIR_CLKS_ALOT_PERIOD_AVG_EN
      check("jit11_period", int'(period_o), 10);
`else
      check("jit11_period", int'(period_o), 11);
`endif
      gap_edge(10);
      check("jit10_period", int'(period_o), 10);
      check("jit10_valid", int'(period_valid_o), 1);

      // Out-of-tolerance period drops lock without a valid pulse
      gap_edge(13);
      check("miss13_locked", int'(locked_o), 0);
      check("miss13_valid", int'(period_valid_o), 0);
      repeat (4) gap_edge(10);
      check("relock_locked", int'(locked_o), 1);

      // Loss of clock after 50 idle cycles, then sticky clear
      timeout_cycles = 16'd50;
      repeat (50) step(1'b0);
      check("to49_lost", int'(lost_o), 0);
      check("to49_locked", int'(locked_o), 1);
      step(1'b0);
      check("to50_lost", int'(lost_o), 1);
      check("to50_locked", int'(locked_o), 0);
      lost_clear = 1'b1;
      step(1'b0);
      lost_clear = 1'b0;
      check("clear_lost", int'(lost_o), 0);

      // Edge coincident with timeout wins; clear coincident with new loss keeps flag
      step(1'b1);
      repeat (50) step(1'b0);
      step(1'b1);
      check("edge_vs_to_lost", int'(lost_o), 0);
      repeat (50) step(1'b0);
      lost_clear = 1'b1;
      step(1'b0);
      lost_clear = 1'b0;
      check("clear_vs_loss_lost", int'(lost_o), 1);

      // Reset mid-ACQUIRE discards everything, then ARM again
      step(1'b1);
      gap_edge(10);
      gap_edge(10);
      check("pre_rst_valid", int'(period_valid_o), 1);
      repeat (3) step(1'b0);
      rst_n = 1'b0;
      step(1'b0);
      check("mid_rst_period", int'(period_o), 0);
      check("mid_rst_valid", int'(period_valid_o), 0);
      check("mid_rst_locked", int'(locked_o), 0);
      check("mid_rst_lost", int'(lost_o), 0);
      rst_n = 1'b1;
      repeat (3) step(1'b0);
      step(1'b1);
      gap_edge(10);
      check("rearm_edge2_valid", int'(period_valid_o), 0);
      gap_edge(10);
      check("rearm_edge3_valid", int'(period_valid_o), 1);
      check("rearm_edge3_period", int'(period_o), 10);
      gap_edge(10);
      gap_edge(10);
      check("rearm_locked", int'(locked_o), 1);

      // Disable clears period and lock
      tracker_en = 1'b0;
      step(1'b0);
      check("dis_period", int'(period_o), 0);
      check("dis_locked", int'(locked_o), 0);
      step(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
